// File: rtl/acia_rx_fsm.sv
// ACIA serial receiver: 8N1, LSB first, mid-bit sampling with start validation and stop check.
// Define ACIA_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of the last three sample cycles.
module acia_rx_fsm #(
    parameter int sym_cnt = 1250,
    parameter int SCW     = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [SCW-1:0] CNT_RELOAD = SCW'(sym_cnt - 1);
    localparam logic [SCW-1:0] CNT_HALF   = SCW'(sym_cnt / 2 - 1);

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           sync_dly_q, sync_dly_d;
    logic [2:0]     state_q, state_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_dat_q, rx_dat_d;
    logic           rx_stb_q, rx_stb_d;
    logic           rx_err_q, rx_err_d;

    logic rx_sync;
    logic fall;
    logic sample_now;
    logic rx_bit;
    logic timer_run;

    assign rx_sync    = sync2_q;
    assign fall       = sync_dly_q & ~sync2_q;
    assign sample_now = (cnt_q == '0);
    assign timer_run  = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

`ifdef ACIA_RX_MAJORITY_EN
    logic maj_a_q, maj_a_d;
    logic maj_b_q, maj_b_d;

    // Early votes are taken two and one cycles before the sample point.
    always_comb begin
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        if (cnt_q == SCW'(2)) maj_a_d = rx_sync;
        if (cnt_q == SCW'(1)) maj_b_d = rx_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
        end
    end

    assign rx_bit = (maj_a_q & maj_b_q) | (maj_a_q & rx_sync) | (maj_b_q & rx_sync);
`else
    assign rx_bit = rx_sync;
`endif

    always_comb begin
        sync1_d    = rx_serial;
        sync2_d    = sync1_q;
        sync_dly_d = sync2_q;
    end

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_dat_d  = rx_dat_q;
        rx_err_d  = rx_err_q;
        rx_stb_d  = 1'b0;

        if (timer_run) begin
            cnt_d = sample_now ? CNT_RELOAD : cnt_q - SCW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (sample_now) begin
                    if (!rx_bit) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (sample_now) begin
                    shift_d = {rx_bit, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (sample_now) begin
                    rx_dat_d = shift_q;
                    rx_stb_d = 1'b1;
                    if (rx_bit) begin
                        rx_err_d = 1'b0;
                        // A start edge already under way in the back half of the stop bit is taken at once.
                        if (!rx_sync) begin
                            state_d = ST_START;
                            cnt_d   = CNT_HALF;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments; reset is synchronous and clears every flop, the
    // shift register included, so a reset mid-frame leaves no partial byte behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sync_dly_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_dat_q   <= 8'h00;
            rx_stb_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_dly_q <= sync_dly_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_dat_q   <= rx_dat_d;
            rx_stb_q   <= rx_stb_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_dat = rx_dat_q;
    assign rx_stb = rx_stb_q;
    assign rx_err = rx_err_q;

    a_stb_single: assert property (@(posedge clk) disable iff (rst) rx_stb_q |=> !rx_stb_q);
    a_cnt_range:  assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_RELOAD);

endmodule

// File: tb/tb_acia_rx_fsm.sv
// Bench for acia_rx_fsm: a full-rate instance checks frame latency and spacing, a fast-rate
// instance takes random frames, false starts, breaks, mid-frame reset and a sample-point glitch.
module tb_acia_rx_fsm;

    localparam int SYM_A = 1250;
    localparam int SCW_A = 11;
    localparam int SYM_B = 16;
    localparam int SCW_B = 5;
    localparam int LAT_NOM = 9 * SYM_A + SYM_A / 2 + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] rx_dat_a, rx_dat_b;
    logic       rx_stb_a, rx_stb_b;
    logic       rx_err_a, rx_err_b;

    always #5 clk = ~clk;

    acia_rx_fsm #(.sym_cnt(SYM_A), .SCW(SCW_A)) dut_a (
        .clk(clk), .rst(rst), .rx_serial(rx_a),
        .rx_dat(rx_dat_a), .rx_stb(rx_stb_a), .rx_err(rx_err_a)
    );

    acia_rx_fsm #(.sym_cnt(SYM_B), .SCW(SCW_B)) dut_b (
        .clk(clk), .rst(rst), .rx_serial(rx_b),
        .rx_dat(rx_dat_b), .rx_stb(rx_stb_b), .rx_err(rx_err_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] dat;
        logic       err;
    } stb_rec_t;

    stb_rec_t got_a[$];
    stb_rec_t got_b[$];

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    int cyc   = 0;

    logic [7:0] last_b_dat = 8'h00;
    logic       last_b_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder and output-stability watcher, sampled on the falling edge.
    logic       rst_at_edge = 1'b1;
    logic       stb_a_prev = 1'b0, stb_b_prev = 1'b0;
    logic [7:0] dat_a_prev = 8'h00, dat_b_prev = 8'h00;
    logic       err_a_prev = 1'b0, err_b_prev = 1'b0;

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (rx_stb_a === 1'b1) got_a.push_back('{cyc, rx_dat_a, rx_err_a});
        if (rx_stb_b === 1'b1) got_b.push_back('{cyc, rx_dat_b, rx_err_b});
        if (!rst_at_edge) begin
            if (rx_stb_a === 1'b1 && stb_a_prev === 1'b1) viol++;
            if (rx_stb_b === 1'b1 && stb_b_prev === 1'b1) viol++;
            if (rx_stb_a !== 1'b1 && (rx_dat_a !== dat_a_prev || rx_err_a !== err_a_prev)) viol++;
            if (rx_stb_b !== 1'b1 && (rx_dat_b !== dat_b_prev || rx_err_b !== err_b_prev)) viol++;
        end
        stb_a_prev = rx_stb_a;
        stb_b_prev = rx_stb_b;
        dat_a_prev = rx_dat_a;
        dat_b_prev = rx_dat_b;
        err_a_prev = rx_err_a;
        err_b_prev = rx_err_b;
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Called #1 after a rising edge; holds the chosen line at v for n rising edges.
    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_bit, input int sym);
        drive(sel, 1'b0, sym);
        for (int i = 0; i < 8; i++) drive(sel, b[i], sym);
        drive(sel, stop_bit, sym);
    endtask

    task automatic expect_b_frame(input string name, input int base, input logic [7:0] exp_dat,
                                  input logic exp_err);
        tests++;
        if (got_b.size() !== base + 1) begin
            fails++;
            $display("FAIL %s count: got %0d strobes, expected 1", name, got_b.size() - base);
        end else begin
            tests++;
            if (got_b[base].dat !== exp_dat || got_b[base].err !== exp_err) begin
                fails++;
                $display("FAIL %s data: got dat=%02h err=%b, expected dat=%02h err=%b",
                         name, got_b[base].dat, got_b[base].err, exp_dat, exp_err);
            end
        end
        last_b_dat = exp_dat;
        last_b_err = exp_err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({rx_stb_a, rx_dat_a, rx_err_a} !== 10'b0) begin
            fails++;
            $display("FAIL reset_a: got stb=%b dat=%02h err=%b, expected 0/00/0", rx_stb_a, rx_dat_a, rx_err_a);
        end
        tests++;
        if ({rx_stb_b, rx_dat_b, rx_err_b} !== 10'b0) begin
            fails++;
            $display("FAIL reset_b: got stb=%b dat=%02h err=%b, expected 0/00/0", rx_stb_b, rx_dat_b, rx_err_b);
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        int base, t0, lat;
        base = got_a.size();
        t0 = cyc + 1;
        send_frame(1'b0, 8'h55, 1'b1, SYM_A);
        drive(1'b0, 1'b1, 10);
        tests++;
        if (got_a.size() !== base + 1) begin
            fails++;
            $display("FAIL latency count: got %0d strobes, expected 1", got_a.size() - base);
        end else begin
            lat = got_a[base].cyc - t0;
            tests++;
            if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
                fails++;
                $display("FAIL latency cycles: got %0d, expected %0d +/-2", lat, LAT_NOM);
            end
            tests++;
            if (got_a[base].dat !== 8'h55 || got_a[base].err !== 1'b0) begin
                fails++;
                $display("FAIL latency data: got dat=%02h err=%b, expected 55/0", got_a[base].dat, got_a[base].err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int base, gap;
        base = got_a.size();
        send_frame(1'b0, 8'hA5, 1'b1, SYM_A);
        send_frame(1'b0, 8'h3C, 1'b1, SYM_A);
        drive(1'b0, 1'b1, 10);
        tests++;
        if (got_a.size() !== base + 2) begin
            fails++;
            $display("FAIL b2b count: got %0d strobes, expected 2", got_a.size() - base);
        end else begin
            gap = got_a[base + 1].cyc - got_a[base].cyc;
            tests++;
            if (gap < 10 * SYM_A - 2 || gap > 10 * SYM_A + 2) begin
                fails++;
                $display("FAIL b2b spacing: got %0d, expected %0d +/-2", gap, 10 * SYM_A);
            end
            tests++;
            if (got_a[base].dat !== 8'hA5 || got_a[base + 1].dat !== 8'h3C ||
                got_a[base].err !== 1'b0 || got_a[base + 1].err !== 1'b0) begin
                fails++;
                $display("FAIL b2b data: got %02h/%b then %02h/%b, expected a5/0 then 3c/0",
                         got_a[base].dat, got_a[base].err, got_a[base + 1].dat, got_a[base + 1].err);
            end
        end
    endtask

    // Reference: every frame with a start bit yields exactly one strobe carrying its byte,
    // flagged in error when its stop bit was low, in transmission order.
    task automatic test_random;
        int         base, gap, n;
        logic [7:0] b;
        logic       sb;
        logic [7:0] exp_dat[$];
        logic       exp_err[$];
        base = got_b.size();
        for (int i = 0; i < 24; i++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(1'b1, b, sb, SYM_B);
            exp_dat.push_back(b);
            exp_err.push_back(~sb);
            gap = sb ? $urandom_range(0, SYM_B) : $urandom_range(3, SYM_B);
            if (gap > 0) drive(1'b1, 1'b1, gap);
        end
        drive(1'b1, 1'b1, 2 * SYM_B);
        n = got_b.size() - base;
        tests++;
        if (n !== exp_dat.size()) begin
            fails++;
            $display("FAIL random count: got %0d strobes, expected %0d", n, exp_dat.size());
        end
        for (int i = 0; i < exp_dat.size() && i < n; i++) begin
            tests++;
            if (got_b[base + i].dat !== exp_dat[i] || got_b[base + i].err !== exp_err[i]) begin
                fails++;
                $display("FAIL random frame %0d: got dat=%02h err=%b, expected dat=%02h err=%b",
                         i, got_b[base + i].dat, got_b[base + i].err, exp_dat[i], exp_err[i]);
            end
        end
        last_b_dat = exp_dat[$];
        last_b_err = exp_err[$];
    endtask

    task automatic test_false_start;
        int base;
        base = got_b.size();
        drive(1'b1, 1'b0, 4);
        drive(1'b1, 1'b1, 2 * SYM_B);
        tests++;
        if (got_b.size() !== base || rx_dat_b !== last_b_dat || rx_err_b !== last_b_err) begin
            fails++;
            $display("FAIL false_start: got %0d strobes dat=%02h err=%b, expected 0 strobes dat=%02h err=%b",
                     got_b.size() - base, rx_dat_b, rx_err_b, last_b_dat, last_b_err);
        end
        base = got_b.size();
        send_frame(1'b1, 8'h81, 1'b1, SYM_B);
        drive(1'b1, 1'b1, SYM_B);
        expect_b_frame("false_start_next", base, 8'h81, 1'b0);
    endtask

    task automatic test_break;
        int base;
        base = got_b.size();
        send_frame(1'b1, 8'hF0, 1'b0, SYM_B);
        drive(1'b1, 1'b0, 5 * SYM_B);
        expect_b_frame("break", base, 8'hF0, 1'b1);
        drive(1'b1, 1'b1, 3);
        base = got_b.size();
        send_frame(1'b1, 8'h12, 1'b1, SYM_B);
        drive(1'b1, 1'b1, SYM_B);
        expect_b_frame("break_recover", base, 8'h12, 1'b0);
    endtask

    // Byte F5: bits 4..7 are high, so after the reset the line stays high to the end of the frame.
    task automatic test_reset_mid;
        int         base;
        logic [7:0] b;
        b = 8'hF5;
        base = got_b.size();
        drive(1'b1, 1'b0, SYM_B);
        for (int i = 0; i < 4; i++) drive(1'b1, b[i], SYM_B);
        drive(1'b1, b[4], SYM_B / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({rx_stb_b, rx_dat_b, rx_err_b} !== 10'b0) begin
            fails++;
            $display("FAIL reset_mid outputs: got stb=%b dat=%02h err=%b, expected 0/00/0",
                     rx_stb_b, rx_dat_b, rx_err_b);
        end
        drive(1'b1, b[4], SYM_B - SYM_B / 2 - 1);
        for (int i = 5; i < 8; i++) drive(1'b1, b[i], SYM_B);
        drive(1'b1, 1'b1, 3 * SYM_B);
        tests++;
        if (got_b.size() !== base) begin
            fails++;
            $display("FAIL reset_mid strobe: got %0d strobes, expected 0", got_b.size() - base);
        end
        last_b_dat = 8'h00;
        last_b_err = 1'b0;
    endtask

    // Zero frame with the line high for exactly the one edge that feeds the bit-3 sample.
    task automatic test_glitch;
        int         base;
        logic [7:0] exp;
`ifdef ACIA_RX_MAJORITY_EN
        exp = 8'h00;
`else
        exp = 8'h08;
`endif
        base = got_b.size();
        drive(1'b1, 1'b0, 4 * SYM_B);
        drive(1'b1, 1'b0, SYM_B / 2);
        drive(1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, SYM_B - SYM_B / 2 - 1);
        drive(1'b1, 1'b0, 4 * SYM_B);
        drive(1'b1, 1'b1, 2 * SYM_B);
        expect_b_frame("glitch", base, exp, 1'b0);
    endtask

    task automatic test_invariants;
        tests++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL invariants: got %0d strobe/hold violations, expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_random();
        test_false_start();
        test_break();
        test_reset_mid();
        test_glitch();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
